// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit producing one bit per clock into HI/LO.
// Magnitudes are processed unsigned; sign correction is applied once in the FIX cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state, state_nx;
  logic                 accept;
  logic                 is_div_q, neg_q_q, neg_r_q, bz_q;
  logic [WIDTH-1:0]     a_q, mb_q;
  logic [2*WIDTH-1:0]   acc, acc_nx;
  logic [CW-1:0]        cnt;

  // Operand magnitudes; only signed ops (op[0]) look at the sign bits.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  assign a_neg = op[0] & a[WIDTH-1];
  assign b_neg = op[0] & b[WIDTH-1];
  assign a_abs = a_neg ? -a : a;
  assign b_abs = b_neg ? -b : b;

  assign accept = (state == IDLE) && start;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt == CW'(1)) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One iteration: shift-add for multiply, restoring step for divide.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH+1:0] div_trial;
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mb_q};
    div_trial = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {2'b00, mb_q};
    acc_nx    = acc;
    if (is_div_q) begin
      if (div_trial[WIDTH+1]) acc_nx = {acc[2*WIDTH-2:0], 1'b0};
      else                    acc_nx = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      if (acc[0]) acc_nx = {mul_sum, acc[WIDTH-1:1]};
      else        acc_nx = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  // Sign-corrected results presented at the FIX edge.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;
  always_comb begin
    prod = neg_q_q ? -acc : acc;
    quot = neg_q_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = neg_r_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // NOTE: all state is plain registers (no memories), so everything is cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_div_q    <= 1'b0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      bz_q        <= 1'b0;
      a_q         <= '0;
      mb_q        <= '0;
      acc         <= '0;
      cnt         <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done <= 1'b0;
      if (accept) begin
        is_div_q    <= op[1];
        neg_q_q     <= a_neg ^ b_neg;
        neg_r_q     <= a_neg;
        bz_q        <= (b == '0);
        a_q         <= a;
        mb_q        <= op[1] ? b_abs : a_abs;
        acc         <= {{WIDTH{1'b0}}, op[1] ? a_abs : b_abs};
        cnt         <= CW'(WIDTH);
        div_by_zero <= 1'b0;
      end else if (state == RUN) begin
        acc <= acc_nx;
        cnt <= cnt - CW'(1);
      end else if (state == FIX) begin
        done <= 1'b1;
        if (is_div_q && bz_q) begin
          lo          <= '1;
          hi          <= a_q;
          div_by_zero <= 1'b1;
        end else if (is_div_q) begin
          lo <= quot;
          hi <= rem;
        end else begin
          lo <= prod[WIDTH-1:0];
          hi <= prod[2*WIDTH-1:WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: stimulus pushes expected HI/LO/flag/latency into a
// scoreboard queue; a monitor pops and compares whenever done pulses.
module tb_mult_div_unit;

  localparam int W = 32;
  localparam logic [1:0] MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("hi", 64'(hi), 64'(e.hi));
        check("lo", 64'(lo), 64'(e.lo));
        check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
        check("latency", 64'(cyc), 64'(e.cyc));
        check("busy_in_done", 64'(busy), 64'(0));
      end
    end
  end

  // Called just after a falling edge; the next rising edge is the accept edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz,
                       input bit expect_done);
    exp_t e;
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    if (expect_done) begin
      e.hi = ehi; e.lo = elo; e.dbz = edbz; e.cyc = cyc + W + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the falling edge where done is seen, so a follow-up issue lands in the done cycle.
  task automatic wait_done(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done === 1'b1) return;
    end
    check("done_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    #12;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_dbz", 64'(div_by_zero), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1);
    check("busy_running", 64'(busy), 64'(1));
    wait_done(60);
    issue(MULT, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1);
    wait_done(60);
    issue(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1);
    wait_done(60);
    issue(DIVU, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1);
    wait_done(60);
    issue(DIVU, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 1'b0, 1);
    check("dbz_cleared_on_accept", 64'(div_by_zero), 64'(0));
    wait_done(60);
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1);
    wait_done(60);
    issue(MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0000, 32'h0000_0006, 1'b0, 1);
    wait_done(60);
    issue(MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1);
    wait_done(60);
    issue(DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1);
    wait_done(60);
    issue(DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0, 1);
    wait_done(60);

    // Start pulse and operand changes while busy must be ignored.
    issue(MULTU, 32'd5, 32'd6, 32'h0, 32'h0000_001E, 1'b0, 1);
    repeat (5) @(negedge clk);
    start = 1'b1; op = DIVU; a = 32'd9; b = 32'd3;
    @(negedge clk);
    start = 1'b0; a = 32'h1234_5678; b = 32'h0;
    check("hi_holds_midrun", 64'(hi), 64'(32'h0000_000F));
    wait_done(60);
    // Back-to-back: issued in the done cycle itself.
    issue(MULTU, 32'd7, 32'd8, 32'h0, 32'h0000_0038, 1'b0, 1);
    wait_done(60);

    // Reset at RUN edge 10 aborts the run without a done pulse.
    issue(MULTU, 32'd3, 32'd4, 32'h0, 32'h0, 1'b0, 0);
    while (cyc < 0) @(posedge clk);
    repeat (9) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_hi", 64'(hi), 64'(0));
    check("abort_lo", 64'(lo), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_idle", 64'(busy), 64'(0));
    issue(MULT, 32'd1234, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FB2E, 1'b0, 1);
    wait_done(60);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
